vanilla_scoreboard_profiler: RTL and testbench
==============================================

# vanilla_scoreboard_profiler

Parametrised successor to the vanilla core's per-register scoreboard tracker, used in the testbench profiling layer. It tracks, for each of `els_p` architectural registers, which of `cat_p` pending-writeback categories are outstanding, including remote DRAM/global/group loads, AMOs, sequential loads and long-latency divides. Beyond the set/clear bits, it measures per-register outstanding age and accumulates per-category statistics: issue count, busy cycles and maximum observed latency. Statistics are readable through a select port. One instance per scoreboard (int or float) sits beside the core in the bench.

## Interface
Parameters:
- `els_p`, 32, number of tracked registers.
- `cat_p`, 6, number of pending categories.
- `cnt_width_p`, 32, width of issue and busy-cycle counters.
- `age_width_p`, 16, width of per-register age and latency values.
- `ignore_r0_p`, 1, when 1, set requests to register 0 are dropped.
- `id_width_lp`, `$clog2(els_p)`, derived.
- `sel_width_lp`, `$clog2(cat_p)` (minimum 1), derived.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `set_v_i`  in  1  set request valid.
- `set_id_i`  in  id_width_lp  register being set.
- `set_cat_i`  in  cat_p  category mask to set; multiple bits allowed.
- `clear_v_i`  in  1  clear request valid; clears all categories of `clear_id_i`.
- `clear_id_i`  in  id_width_lp  register being cleared.
- `clear_all_i`  in  1  drop all pending state (flush / hart reset).
- `stat_sel_i`  in  sel_width_lp  category selected for stat readout.
- `stat_clear_i`  in  1  zero all statistics.
- `sb_o`  out  els_p*cat_p  pending bits; bit `[r*cat_p+c]` means register r has category c pending.
- `busy_cat_o`  out  cat_p  OR over registers of each category.
- `stat_issue_o`  out  cnt_width_p  set events for the selected category.
- `stat_busy_cycles_o`  out  cnt_width_p  cycles in which `busy_cat_o[sel]` was 1.
- `stat_max_lat_o`  out  age_width_p  largest completed latency in the selected category.

## Operation
- **State:** `pend_r[els_p][cat_p]`, `age_r[els_p]`, and per category `issue_r`, `busy_r`, `maxlat_r`. All are 0 on reset.
- **Register idle:** a register is idle when all of its `pend_r` bits are 0.
- **Set:**
  - `pend_r[id] |= set_cat_i`.
  - If the register was idle, `age_r[id] <= 0`; otherwise age is retained.
  - `issue_r[c]` increments for every c in `set_cat_i`.
  - A set with an all-zero mask is a no-op.
  - With `ignore_r0_p=1`, a set with `set_id_i==0` is fully ignored, including issue counts.
- **Clear on a pending register:**
  - Latency L = `age_r[id]+1`, saturating at all-ones.
  - For each c pending on `id`, `maxlat_r[c] <= max(maxlat_r[c], L)`.
  - All bits of `id` are then cleared.
- **Clear on an idle register:** no effect, no stat update.
- **Set and clear to the same id in one cycle:** the clear is processed first (latency recorded), then the set is applied. The register ends pending with `set_cat_i` and `age_r=0`.
- **Set and clear to different ids in one cycle:** both are applied independently.
- **Age:** each cycle, every pending register not cleared or newly set from idle increments `age_r`, saturating at `2^age_width_p-1`.
- **Busy cycles:** `busy_r[c]` increments each cycle where `busy_cat_o[c]==1` (registered value), saturating.
- **Issue counter width:** `issue_r` saturates at all-ones.
- **`clear_all_i`:**
  - Zeroes `pend_r` and `age_r` without recording latency.
  - Takes priority over set and clear in the same cycle; no issue increment.
- **`stat_clear_i`:**
  - Zeroes `issue_r`, `busy_r` and `maxlat_r`.
  - Takes priority over any coincident increment or max update (result 0).
  - Does not affect `pend_r`.
- **Stat readout:** the stat outputs are a combinational mux of the selected category's registers. A `stat_sel_i >= cat_p` returns 0 on all three outputs.

## Timing
- All state updates occur on the rising `clk_i` edge. `reset_n_i` low clears all state immediately (asynchronously); deassertion is assumed synchronised externally.
- **`sb_o` and `busy_cat_o`:** driven directly from registers. A set sampled at edge k is visible after edge k; a clear likewise.
- **Latency definition:** a set at edge k followed by a clear at edge k+n records L=n (minimum 1, for a clear one cycle after the set).
- **Stat output latency:** 0 cycles from `stat_sel_i`; one cycle from the causing event.
- **Reset mid-operation:** all outputs read 0 the cycle after reset assertion; no partial stats are retained.

## Test plan
- Reset, then idle for 10 cycles. Required: `sb_o=0`, `busy_cat_o=0`, all stats 0 for every `stat_sel_i`.
- Set id 5 with mask 6'b000101 at edge 1, clear id 5 at edge 4. Required: `sb_o` bits 30 and 32 high for 3 cycles. `stat_sel_i=0` and `=2` each show issue 1, max_lat 3, busy_cycles 3.
- Set id 7 cat 1 at edge 1; at edge 3 clear id 7 and set id 7 cat 1 together; clear at edge 8. Required: max_lat=5 (first recording 2, second 5), issue=2, bit remains high continuously.
- Set id 0 cat 0 with `ignore_r0_p=1`. Required: `sb_o` unchanged, issue 0. Clear of idle id 9: max_lat unchanged.
- With `age_width_p=4`, set id 3 cat 4 and hold 40 cycles, then clear. Required: max_lat=15 (saturated). Then `stat_clear_i` together with a new set on cat 4. Required: issue 0 afterwards.
- Assert `clear_all_i` with 4 registers pending and a coincident set. Required: `sb_o=0` next cycle, max_lat unchanged. Assert `reset_n_i` low mid-cycle. Required: outputs 0 before the next edge.

Source files
------------

// File: rtl/vanilla_scoreboard_profiler.sv
// Per-register pending-writeback scoreboard with outstanding-age tracking and
// per-category issue / busy-cycle / max-latency statistics for bench profiling.
module vanilla_scoreboard_profiler #(
    parameter int els_p        = 32,
    parameter int cat_p        = 6,
    parameter int cnt_width_p  = 32,
    parameter int age_width_p  = 16,
    parameter int ignore_r0_p  = 1,
    parameter int id_width_lp  = $clog2(els_p),
    parameter int sel_width_lp = (cat_p > 1) ? $clog2(cat_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     set_v_i,
    input  logic [id_width_lp-1:0]   set_id_i,
    input  logic [cat_p-1:0]         set_cat_i,
    input  logic                     clear_v_i,
    input  logic [id_width_lp-1:0]   clear_id_i,
    input  logic                     clear_all_i,
    input  logic [sel_width_lp-1:0]  stat_sel_i,
    input  logic                     stat_clear_i,
    output logic [els_p*cat_p-1:0]   sb_o,
    output logic [cat_p-1:0]         busy_cat_o,
    output logic [cnt_width_p-1:0]   stat_issue_o,
    output logic [cnt_width_p-1:0]   stat_busy_cycles_o,
    output logic [age_width_p-1:0]   stat_max_lat_o
);

    localparam logic [age_width_p-1:0] AGE_ONE = 1;
    localparam logic [cnt_width_p-1:0] CNT_ONE = 1;

    logic [cat_p-1:0]       pend_q   [els_p];
    logic [cat_p-1:0]       pend_d   [els_p];
    logic [age_width_p-1:0] age_q    [els_p];
    logic [age_width_p-1:0] age_d    [els_p];
    logic [cnt_width_p-1:0] issue_q  [cat_p];
    logic [cnt_width_p-1:0] issue_d  [cat_p];
    logic [cnt_width_p-1:0] busy_q   [cat_p];
    logic [cnt_width_p-1:0] busy_d   [cat_p];
    logic [age_width_p-1:0] maxlat_q [cat_p];
    logic [age_width_p-1:0] maxlat_d [cat_p];

    logic                   set_ok;
    logic                   clr_ok;
    logic [age_width_p-1:0] clr_lat;
    logic [cat_p-1:0]       busy_cat;

    always_comb begin
        busy_cat = '0;
        sb_o     = '0;
        for (int unsigned r = 0; r < els_p; r++) begin
            busy_cat                 = busy_cat | pend_q[r];
            sb_o[r*cat_p +: cat_p]   = pend_q[r];
        end
    end

    assign busy_cat_o = busy_cat;

    always_comb begin
        set_ok  = set_v_i && (set_cat_i != '0) && !clear_all_i &&
                  !((ignore_r0_p != 0) && (set_id_i == '0));
        clr_ok  = clear_v_i && !clear_all_i && (pend_q[clear_id_i] != '0);
        clr_lat = (age_q[clear_id_i] == '1) ? '1 : age_q[clear_id_i] + AGE_ONE;
    end

    // Same-id set+clear: the clear wins first, so the set then starts from idle.
    always_comb begin
        for (int unsigned r = 0; r < els_p; r++) begin
            logic hit_clr;
            logic hit_set;
            hit_clr   = clr_ok && (clear_id_i == id_width_lp'(r));
            hit_set   = set_ok && (set_id_i == id_width_lp'(r));
            pend_d[r] = pend_q[r];
            age_d[r]  = age_q[r];
            if (clear_all_i) begin
                pend_d[r] = '0;
                age_d[r]  = '0;
            end else begin
                if (hit_clr) pend_d[r] = '0;
                if (hit_set) pend_d[r] = pend_d[r] | set_cat_i;
                if (hit_clr || (hit_set && (pend_q[r] == '0))) begin
                    age_d[r] = '0;
                end else if ((pend_q[r] != '0) && (age_q[r] != '1)) begin
                    age_d[r] = age_q[r] + AGE_ONE;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < cat_p; c++) begin
            issue_d[c]  = issue_q[c];
            busy_d[c]   = busy_q[c];
            maxlat_d[c] = maxlat_q[c];
            if (stat_clear_i) begin
                issue_d[c]  = '0;
                busy_d[c]   = '0;
                maxlat_d[c] = '0;
            end else begin
                if (set_ok && set_cat_i[c] && (issue_q[c] != '1))
                    issue_d[c] = issue_q[c] + CNT_ONE;
                if (busy_cat[c] && (busy_q[c] != '1))
                    busy_d[c] = busy_q[c] + CNT_ONE;
                if (clr_ok && pend_q[clear_id_i][c] && (clr_lat > maxlat_q[c]))
                    maxlat_d[c] = clr_lat;
            end
        end
    end

    always_comb begin
        stat_issue_o       = '0;
        stat_busy_cycles_o = '0;
        stat_max_lat_o     = '0;
        if (int'(stat_sel_i) < cat_p) begin
            stat_issue_o       = issue_q[stat_sel_i];
            stat_busy_cycles_o = busy_q[stat_sel_i];
            stat_max_lat_o     = maxlat_q[stat_sel_i];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned r = 0; r < els_p; r++) begin
                pend_q[r] <= '0;
                age_q[r]  <= '0;
            end
            for (int unsigned c = 0; c < cat_p; c++) begin
                issue_q[c]  <= '0;
                busy_q[c]   <= '0;
                maxlat_q[c] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < els_p; r++) begin
                pend_q[r] <= pend_d[r];
                age_q[r]  <= age_d[r];
            end
            for (int unsigned c = 0; c < cat_p; c++) begin
                issue_q[c]  <= issue_d[c];
                busy_q[c]   <= busy_d[c];
                maxlat_q[c] <= maxlat_d[c];
            end
        end
    end

endmodule

// File: tb/tb_vanilla_scoreboard_profiler.sv
// Bench for vanilla_scoreboard_profiler: vector table with an expected-result queue,
// plus hand sequences for age saturation, clear_all and asynchronous reset.
module tb_vanilla_scoreboard_profiler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        set_v, clr_v, clr_all, st_clr;
    logic [4:0]  set_id, clr_id;
    logic [5:0]  set_cat;
    logic [2:0]  sel;

    logic [191:0] sb_a, sb_b;
    logic [5:0]   busy_a, busy_b;
    logic [31:0]  iss_a, iss_b, bcyc_a, bcyc_b;
    logic [15:0]  max_a;
    logic [3:0]   max_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vanilla_scoreboard_profiler u_dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .set_v_i(set_v), .set_id_i(set_id), .set_cat_i(set_cat),
        .clear_v_i(clr_v), .clear_id_i(clr_id), .clear_all_i(clr_all),
        .stat_sel_i(sel), .stat_clear_i(st_clr),
        .sb_o(sb_a), .busy_cat_o(busy_a),
        .stat_issue_o(iss_a), .stat_busy_cycles_o(bcyc_a), .stat_max_lat_o(max_a)
    );

    vanilla_scoreboard_profiler #(.age_width_p(4)) u_dut4 (
        .clk_i(clk), .reset_n_i(rst_n),
        .set_v_i(set_v), .set_id_i(set_id), .set_cat_i(set_cat),
        .clear_v_i(clr_v), .clear_id_i(clr_id), .clear_all_i(clr_all),
        .stat_sel_i(sel), .stat_clear_i(st_clr),
        .sb_o(sb_b), .busy_cat_o(busy_b),
        .stat_issue_o(iss_b), .stat_busy_cycles_o(bcyc_b), .stat_max_lat_o(max_b)
    );

    typedef struct {
        logic        set_v;
        logic [4:0]  set_id;
        logic [5:0]  set_cat;
        logic        clr_v;
        logic [4:0]  clr_id;
        logic        clr_all;
        logic        st_clr;
        logic [2:0]  sel;
        logic [4:0]  chk_id;
        logic [5:0]  exp_pend;
        logic [5:0]  exp_busy;
        logic [31:0] exp_issue;
        logic [31:0] exp_bcyc;
        logic [15:0] exp_max;
    } vec_t;

    vec_t tbl[22];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic sv, input int sid, input logic [5:0] sc,
                                input logic cv, input int cid, input logic ca,
                                input logic stc, input int sl, input int kid,
                                input logic [5:0] ep, input logic [5:0] eb,
                                input int ei, input int ebc, input int em);
        vec_t v;
        v.set_v = sv;  v.set_id = 5'(sid); v.set_cat = sc;
        v.clr_v = cv;  v.clr_id = 5'(cid); v.clr_all = ca; v.st_clr = stc;
        v.sel = 3'(sl); v.chk_id = 5'(kid); v.exp_pend = ep; v.exp_busy = eb;
        v.exp_issue = 32'(ei); v.exp_bcyc = 32'(ebc); v.exp_max = 16'(em);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        set_v = v.set_v; set_id = v.set_id; set_cat = v.set_cat;
        clr_v = v.clr_v; clr_id = v.clr_id; clr_all = v.clr_all;
        st_clr = v.st_clr; sel = v.sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    initial begin
        vec_t e;
        rst_n = 1'b0;
        drive(mk(0,0,6'b0,0,0,0,0,0,0,0,0,0,0,0));

        // Vectors are applied one per rising edge and checked just after it.
        tbl[0]  = mk(1,5,6'b000101,0,0,0,0, 0, 5,6'b000101,6'b000101, 1,0,0);
        tbl[1]  = mk(0,0,6'b0,     0,0,0,0, 0, 5,6'b000101,6'b000101, 1,1,0);
        tbl[2]  = mk(0,0,6'b0,     0,0,0,0, 0, 5,6'b000101,6'b000101, 1,2,0);
        tbl[3]  = mk(0,0,6'b0,     1,5,0,0, 0, 5,6'b0,     6'b0,      1,3,3);
        tbl[4]  = mk(0,0,6'b0,     0,0,0,0, 2, 5,6'b0,     6'b0,      1,3,3);
        tbl[5]  = mk(0,0,6'b0,     0,0,0,0, 1, 5,6'b0,     6'b0,      0,0,0);
        tbl[6]  = mk(0,0,6'b0,     0,0,0,0, 7, 5,6'b0,     6'b0,      0,0,0);
        tbl[7]  = mk(0,0,6'b0,     0,0,0,1, 0, 5,6'b0,     6'b0,      0,0,0);
        tbl[8]  = mk(1,7,6'b000010,0,0,0,0, 1, 7,6'b000010,6'b000010, 1,0,0);
        tbl[9]  = mk(0,0,6'b0,     0,0,0,0, 1, 7,6'b000010,6'b000010, 1,1,0);
        tbl[10] = mk(1,7,6'b000010,1,7,0,0, 1, 7,6'b000010,6'b000010, 2,2,2);
        tbl[11] = mk(0,0,6'b0,     0,0,0,0, 1, 7,6'b000010,6'b000010, 2,3,2);
        tbl[12] = mk(0,0,6'b0,     0,0,0,0, 1, 7,6'b000010,6'b000010, 2,4,2);
        tbl[13] = mk(0,0,6'b0,     0,0,0,0, 1, 7,6'b000010,6'b000010, 2,5,2);
        tbl[14] = mk(0,0,6'b0,     0,0,0,0, 1, 7,6'b000010,6'b000010, 2,6,2);
        tbl[15] = mk(0,0,6'b0,     1,7,0,0, 1, 7,6'b0,     6'b0,      2,7,5);
        tbl[16] = mk(0,0,6'b0,     0,0,0,0, 1, 7,6'b0,     6'b0,      2,7,5);
        tbl[17] = mk(1,0,6'b000001,0,0,0,0, 0, 0,6'b0,     6'b0,      0,0,0);
        tbl[18] = mk(0,0,6'b0,     1,9,0,0, 1, 9,6'b0,     6'b0,      2,7,5);
        tbl[19] = mk(1,10,6'b001000,1,9,0,0,3,10,6'b001000,6'b001000, 1,0,0);
        tbl[20] = mk(1,11,6'b001000,1,10,0,0,3,10,6'b0,    6'b001000, 2,1,1);
        tbl[21] = mk(0,0,6'b0,     1,11,0,0,3,11,6'b0,     6'b0,      2,2,1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) step();
        chk("reset_sb", 64'(sb_a != '0), 64'd0);
        chk("reset_sb4", 64'(sb_b != '0), 64'd0);
        chk("reset_busy", 64'(busy_a), 64'd0);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            chk($sformatf("reset_issue_s%0d", s), 64'(iss_a), 64'd0);
            chk($sformatf("reset_bcyc_s%0d", s), 64'(bcyc_a), 64'd0);
            chk($sformatf("reset_max_s%0d", s), 64'(max_a), 64'd0);
        end

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            step();
            e = exp_q.pop_front();
            chk($sformatf("v%0d_pend", i), 64'(sb_a[int'(e.chk_id)*6 +: 6]), 64'(e.exp_pend));
            chk($sformatf("v%0d_busy", i), 64'(busy_a), 64'(e.exp_busy));
            chk($sformatf("v%0d_issue", i), 64'(iss_a), 64'(e.exp_issue));
            chk($sformatf("v%0d_bcyc", i), 64'(bcyc_a), 64'(e.exp_bcyc));
            chk($sformatf("v%0d_max", i), 64'(max_a), 64'(e.exp_max));
        end

        // Long hold on id 3 / category 4: latency 41, saturates at 15 in the narrow instance.
        drive(mk(1,3,6'b010000,0,0,0,0,4,0,0,0,0,0,0));
        step();
        drive(mk(0,0,6'b0,0,0,0,0,4,0,0,0,0,0,0));
        repeat (40) step();
        drive(mk(0,0,6'b0,1,3,0,0,4,0,0,0,0,0,0));
        step();
        chk("sat_max_wide", 64'(max_a), 64'd41);
        chk("sat_max_narrow", 64'(max_b), 64'd15);
        chk("sat_issue", 64'(iss_a), 64'd1);
        chk("sat_bcyc", 64'(bcyc_b), 64'd41);
        drive(mk(1,3,6'b010000,0,0,0,1,4,0,0,0,0,0,0));
        step();
        chk("stclr_issue", 64'(iss_a), 64'd0);
        chk("stclr_issue_narrow", 64'(iss_b), 64'd0);
        chk("stclr_max", 64'(max_a), 64'd0);
        chk("stclr_pend3", 64'(sb_a[18 +: 6]), 64'h10);
        drive(mk(0,0,6'b0,0,0,0,0,4,0,0,0,0,0,0));
        step();
        chk("stclr_bcyc_next", 64'(bcyc_a), 64'd1);

        // Four registers pending (1,2,3,4), then clear_all with a coincident set and clear.
        drive(mk(1,1,6'b000001,0,0,0,0,0,0,0,0,0,0,0)); step();
        drive(mk(1,2,6'b000001,0,0,0,0,0,0,0,0,0,0,0)); step();
        drive(mk(1,4,6'b000001,0,0,0,0,0,0,0,0,0,0,0)); step();
        chk("pre_flush_issue", 64'(iss_a), 64'd3);
        chk("pre_flush_bcyc", 64'(bcyc_a), 64'd2);
        drive(mk(1,6,6'b000001,1,1,1,0,0,0,0,0,0,0,0)); step();
        chk("flush_sb", 64'(sb_a != '0), 64'd0);
        chk("flush_busy", 64'(busy_a), 64'd0);
        chk("flush_issue", 64'(iss_a), 64'd3);
        chk("flush_max", 64'(max_a), 64'd0);
        chk("flush_bcyc", 64'(bcyc_a), 64'd3);

        // Asynchronous reset asserted between edges.
        drive(mk(1,2,6'b000001,0,0,0,0,0,0,0,0,0,0,0)); step();
        drive(mk(0,0,6'b0,0,0,0,0,0,0,0,0,0,0,0));
        chk("prerst_pend2", 64'(sb_a[12 +: 6]), 64'd1);
        chk("prerst_issue", 64'(iss_a), 64'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sb", 64'(sb_a != '0), 64'd0);
        chk("rst_sb4", 64'(sb_b != '0), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_issue", 64'(iss_a), 64'd0);
        chk("rst_bcyc", 64'(bcyc_a), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
